bft_client_port: RTL
====================

# bft_client_port

Leaf endpoint of the BFT packet network, at the opposite end of the valid/backpressure link that the tree switches speak. It buffers client packets in a TX FIFO and injects them into the leaf switch port, observing that port's backpressure. It accepts packets delivered by the switch into an RX FIFO and drives backpressure toward the switch from registered state only. Packets addressed to the endpoint's own address loop back locally and never enter the network.

## Interface
- `N`, 8, number of clients in the tree
- `A_W`, `$clog2(N)+1`, address width
- `D_W`, 32, payload width
- `SELF`, 0, this endpoint's address (0..N-1)
- `TX_DEPTH`, 4, TX FIFO entries, power of two, ≥2
- `RX_DEPTH`, 4, RX FIFO entries, power of two, ≥2
- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: reset, synchronous, active-high
- `ce` in 1: clock enable
- `cl_tx_v` in 1: client TX request valid
- `cl_tx_rdy` out 1: TX FIFO can accept
- `cl_tx_addr` in A_W: destination address
- `cl_tx_data` in D_W: payload
- `net_o_v` out 1: valid toward switch leaf input
- `net_o_addr` out A_W: address toward switch
- `net_o_data` out D_W: data toward switch
- `net_i_bp` in 1: switch input backpressure; combinational from `net_o_v`
- `net_i_v` in 1: valid from switch leaf output
- `net_i_data` in D_W: data from switch
- `net_o_bp` out 1: backpressure toward switch output
- `cl_rx_v` out 1: RX data valid to client
- `cl_rx_rdy` in 1: client accepts RX data
- `cl_rx_data` out D_W: RX payload
- `tx_pkts` out 16: packets that left the TX FIFO (network or loopback); wraps
- `rx_pkts` out 16: packets pushed into the RX FIFO; wraps
- `rx_err` out 1: sticky protocol-error flag

## Operation
- TX push: when `ce & cl_tx_v & cl_tx_rdy`. `cl_tx_rdy = ce & (tx_count != TX_DEPTH)`; it does not depend on `cl_tx_v` or on the address.
- TX head, network case (head addr ≠ SELF):
  - `net_o_v = ce & ~tx_empty`.
  - `net_o_addr` and `net_o_data` carry the head entry.
  - Pop when `net_o_v & ~net_i_bp`.
  - `net_o_v` must never depend combinationally on `net_i_bp`, which would form a combinational loop with the switch.
  - A held packet keeps addr and data stable until it is accepted.
- TX head, loopback case (head addr == SELF):
  - `net_o_v = 0`.
  - The head moves into the RX FIFO in a cycle with `ce`, no `net_i_v`, and RX not full.
  - The network always beats loopback for the RX push.
- RX:
  - `net_o_bp = ~ce | (rx_count == RX_DEPTH)`, computed from registered count only. A same-cycle client pop does not lower it.
  - Any `net_i_v` with `net_o_bp` low is pushed into the RX FIFO.
  - `net_i_v` while `net_o_bp` is high is a protocol violation: the packet is dropped and `rx_err` is set until reset.
- RX pop: when `cl_rx_v & cl_rx_rdy`. `cl_rx_v = ce & ~rx_empty`, and `cl_rx_data` is the head entry.
- Counters: each of `tx_pkts` and `rx_pkts` increments by 1 per event, modulo 2^16.
- `ce` low: every pointer, count, counter and flag holds. Outputs are masked as stated above.
- Reset values: `net_o_v` 0, `net_o_bp` 0, `cl_tx_rdy` 1 (when `ce` is high), `cl_rx_v` 0, `tx_pkts` 0, `rx_pkts` 0, `rx_err` 0, FIFOs empty.
- Reset mid-operation: all buffered and held packets are discarded. There is no partial state.

## Timing
- TX: a client push in cycle t gives `net_o_v` high in cycle t+1 (registered FIFO, no bypass). If `net_i_bp` is low in t+1, that is the transfer cycle.
- Back-to-back: with a full TX FIFO and `net_i_bp` low, one packet transfers per cycle.
- Simultaneous TX push and pop at `tx_count == TX_DEPTH`: the push is refused, because `cl_tx_rdy` is low.
- Simultaneous TX push and pop at other counts: both occur and the count is unchanged.
- RX: a network push in cycle t gives `cl_rx_v` in cycle t+1.
- Loopback: the head becomes eligible in cycle t; the packet appears on `cl_rx_v` in t+1 if the RX push was granted in t.
- Full RX: `net_o_bp` rises the cycle after the push that fills the FIFO. It falls the cycle after the first pop.

## Test plan
- Reset, then push addr=3, data=0xA5A5_0001 (SELF=0) → `net_o_v`=1 with that addr/data one cycle later. Hold `net_i_bp`=1 for 3 cycles → addr/data stable. Release → one transfer, `tx_pkts`=1.
- Fill TX with 4 packets while `net_i_bp`=1 → `cl_tx_rdy`=0. Release bp → 4 transfers on consecutive cycles, in order.
- Drive `net_i_v` 5 times with `cl_rx_rdy`=0, RX_DEPTH=4 → `net_o_bp`=1 after the 4th push. Drive a 5th `net_i_v` under bp → dropped, `rx_err`=1, `rx_pkts`=4.
- TX addr=0 (SELF) → `net_o_v` stays 0 and the packet appears on `cl_rx_v`. Hold `net_i_v` high the same cycles → network packets are delivered first and loopback waits.
- `ce` low for 5 cycles mid-stream → `net_o_v`=0, `net_o_bp`=1, counters frozen. Restore → operation resumes with no loss.
- Assert `rst` with both FIFOs partly full → next cycle `net_o_v`=0, `cl_rx_v`=0, counters 0, `rx_err` 0.

Source files
------------

// File: rtl/bft_client_port.sv
// BFT leaf endpoint: TX FIFO toward the leaf switch, RX FIFO from it, and local
// loopback for packets addressed to this endpoint's own address.
module bft_client_port #(
   parameter int N        = 8,
   parameter int A_W      = $clog2(N) + 1,
   parameter int D_W      = 32,
   parameter int SELF     = 0,
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ce,
   input  logic           cl_tx_v,
   output logic           cl_tx_rdy,
   input  logic [A_W-1:0] cl_tx_addr,
   input  logic [D_W-1:0] cl_tx_data,
   output logic           net_o_v,
   output logic [A_W-1:0] net_o_addr,
   output logic [D_W-1:0] net_o_data,
   input  logic           net_i_bp,
   input  logic           net_i_v,
   input  logic [D_W-1:0] net_i_data,
   output logic           net_o_bp,
   output logic           cl_rx_v,
   input  logic           cl_rx_rdy,
   output logic [D_W-1:0] cl_rx_data,
   output logic [15:0]    tx_pkts,
   output logic [15:0]    rx_pkts,
   output logic           rx_err
);

   localparam int TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int TX_CW = TX_AW + 1;
   localparam int RX_CW = RX_AW + 1;
   localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
   localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
   localparam logic [A_W-1:0]   SELF_ADDR   = A_W'(SELF);

   // Storage (data only, never reset)
   logic [A_W-1:0]   r_tx_addr_mem [TX_DEPTH];
   logic [D_W-1:0]   r_tx_data_mem [TX_DEPTH];
   logic [D_W-1:0]   r_rx_data_mem [RX_DEPTH];

   // Control state
   logic [TX_AW-1:0] r_tx_wptr;
   logic [TX_AW-1:0] r_tx_rptr;
   logic [TX_CW-1:0] r_tx_count;
   logic [RX_AW-1:0] r_rx_wptr;
   logic [RX_AW-1:0] r_rx_rptr;
   logic [RX_CW-1:0] r_rx_count;
   logic [15:0]      r_tx_pkts;
   logic [15:0]      r_rx_pkts;
   logic             r_rx_err;

   logic             w_tx_empty;
   logic             w_tx_full;
   logic [A_W-1:0]   w_head_addr;
   logic [D_W-1:0]   w_head_data;
   logic             w_head_self;
   logic             w_tx_push;
   logic             w_net_pop;
   logic             w_lb;
   logic             w_tx_pop;
   logic             w_rx_empty;
   logic             w_rx_full;
   logic             w_rx_push_net;
   logic             w_rx_push;
   logic             w_rx_pop;
   logic [D_W-1:0]   w_rx_push_data;
   logic             w_err_set;

   assign w_tx_empty  = (r_tx_count == '0);
   assign w_tx_full   = (r_tx_count == TX_FULL_CNT);
   assign w_head_addr = r_tx_addr_mem[r_tx_rptr];
   assign w_head_data = r_tx_data_mem[r_tx_rptr];
   assign w_head_self = (w_head_addr == SELF_ADDR);

   assign w_rx_empty  = (r_rx_count == '0);
   assign w_rx_full   = (r_rx_count == RX_FULL_CNT);

   // net_o_v is built from registered state and ce only, never from net_i_bp
   assign cl_tx_rdy   = ce & ~w_tx_full;
   assign net_o_v     = ce & ~w_tx_empty & ~w_head_self;
   assign net_o_addr  = w_head_addr;
   assign net_o_data  = w_head_data;
   assign net_o_bp    = ~ce | w_rx_full;
   assign cl_rx_v     = ce & ~w_rx_empty;
   assign cl_rx_data  = r_rx_data_mem[r_rx_rptr];
   assign tx_pkts     = r_tx_pkts;
   assign rx_pkts     = r_rx_pkts;
   assign rx_err      = r_rx_err;

   assign w_tx_push      = ce & cl_tx_v & cl_tx_rdy;
   assign w_net_pop      = net_o_v & ~net_i_bp;
   // Network traffic owns the RX write port; loopback only fills idle cycles
   assign w_lb           = ce & ~w_tx_empty & w_head_self & ~net_i_v & ~w_rx_full;
   assign w_tx_pop       = w_net_pop | w_lb;
   assign w_rx_push_net  = ce & net_i_v & ~w_rx_full;
   assign w_rx_push      = w_rx_push_net | w_lb;
   assign w_rx_push_data = w_rx_push_net ? net_i_data : w_head_data;
   assign w_rx_pop       = cl_rx_v & cl_rx_rdy;
   assign w_err_set      = ce & net_i_v & w_rx_full;

   always_ff @(posedge clk) begin
      if (w_tx_push) begin
         r_tx_addr_mem[r_tx_wptr] <= cl_tx_addr;
         r_tx_data_mem[r_tx_wptr] <= cl_tx_data;
      end
      if (w_rx_push) begin
         r_rx_data_mem[r_rx_wptr] <= w_rx_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_count <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_count <= r_tx_count + 1'b1;
            2'b01:   r_tx_count <= r_tx_count - 1'b1;
            default: r_tx_count <= r_tx_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_wptr  <= '0;
         r_rx_rptr  <= '0;
         r_rx_count <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_count <= r_rx_count + 1'b1;
            2'b01:   r_rx_count <= r_rx_count - 1'b1;
            default: r_rx_count <= r_rx_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_pkts <= '0;
         r_rx_pkts <= '0;
         r_rx_err  <= 1'b0;
      end else begin
         if (w_tx_pop)  r_tx_pkts <= r_tx_pkts + 16'd1;
         if (w_rx_push) r_rx_pkts <= r_rx_pkts + 16'd1;
         if (w_err_set) r_rx_err  <= 1'b1;
      end
   end

endmodule
